// File: rtl/bcd_countdown_timer_if.sv
// Bus between the minute-adjust stage and the BCD countdown timer:
// load/start/stop controls in, live MM:SS time and status out.
interface bcd_countdown_timer_if;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic [15:0] time_out;
    logic        running;
    logic        done;
    logic        sec_tick;
    logic        load_err;

    modport master (
        output load, load_value, start, stop,
        input  time_out, running, done, sec_tick, load_err
    );

    modport slave (
        input  load, load_value, start, stop,
        output time_out, running, done, sec_tick, load_err
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: loads a validated preset, decrements once per
// TICK_DIV clocks while running, and latches done at 00:00.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input logic                  clk,
    input logic                  reset,
    bcd_countdown_timer_if.slave bus
);
    localparam int unsigned PcntW = $clog2(TICK_DIV);
    localparam logic [PcntW-1:0] PcntMax = PcntW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [15:0]      r_time;
    logic [PcntW-1:0] r_pcnt;
    logic             r_sec_tick;
    logic             r_load_err;

    logic [15:0]      w_dec;
    logic             w_load_ok;
    logic             w_time_zero;
    logic             w_wrap;

    assign w_load_ok = (bus.load_value[15:12] <= 4'd9) && (bus.load_value[11:8] <= 4'd9) &&
                       (bus.load_value[7:4] <= 4'd5) && (bus.load_value[3:0] <= 4'd9);
    assign w_time_zero = (r_time == 16'h0000);
    assign w_wrap      = (r_pcnt == PcntMax);

    // Digit-serial borrow chain: each digit only moves when all lower digits were zero.
    always_comb begin
        w_dec = r_time;
        if (r_time[3:0] != 4'd0) begin
            w_dec[3:0] = r_time[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_time[7:4] != 4'd0) begin
                w_dec[7:4] = r_time[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_time[11:8] != 4'd0) begin
                    w_dec[11:8] = r_time[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_time[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_time     <= 16'h0000;
            r_pcnt     <= '0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.load && w_load_ok) begin
                r_time  <= bus.load_value;
                r_state <= StIdle;
                r_pcnt  <= '0;
            end else begin
                // A rejected load is flagged, then start/stop proceed as if no load came.
                if (bus.load) begin
                    r_load_err <= 1'b1;
                end
                unique case (r_state)
                    StIdle: begin
                        if (bus.start && !w_time_zero) begin
                            r_state <= StRun;
                            r_pcnt  <= '0;
                        end
                    end
                    StRun: begin
                        if (bus.stop) begin
                            r_state <= StIdle;
                            r_pcnt  <= '0;
                        end else if (w_wrap) begin
                            r_pcnt <= '0;
                            if (!w_time_zero) begin
                                r_time     <= w_dec;
                                r_sec_tick <= 1'b1;
                                if (w_dec == 16'h0000) begin
                                    r_state <= StDone;
                                end
                            end
                        end else begin
                            r_pcnt <= r_pcnt + PcntW'(1);
                        end
                    end
                    StDone: begin
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.time_out = r_time;
    assign bus.running  = (r_state == StRun);
    assign bus.done     = (r_state == StDone);
    assign bus.sec_tick = r_sec_tick;
    assign bus.load_err = r_load_err;
endmodule
